cache_ctrl_nway_wb: RTL and testbench

- Parametrised successor to the current 2-way cache controller FSM.
- Drives tag/LRU/line/data strobes and memory handshake for an N-way set-associative cache with multi-beat line transfers.
- Selectable write policy: write-through/no-allocate or write-back/write-allocate, with dirty-victim eviction.
- Sits between the CPU request port and the memory interface; the tag/way-select datapath is external and supplies hit and victim_dirty.

---
 rtl/cache_ctrl_pkg.sv | 85 ++++++++
 rtl/cache_beat_counter.sv | 51 +++++
 rtl/cache_ctrl_nway_wb.sv | 172 +++++++++++++++++
 tb/tb_cache_ctrl_nway_wb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared state encoding, output bundle and helpers for the
//               N-way write-back cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        HIT    = 3'd2,
        WT_WR  = 3'd3,
        WB     = 3'd4,
        REFILL = 3'd5,
        FILL   = 3'd6,
        DONE   = 3'd7
    } state_e;

    typedef struct packed {
        logic cpu_ready;
        logic mem_access;
        logic mem_read;
        logic mem_write;
        logic write_cache;
        logic fill_sel;
        logic write_tag;
        logic write_lru;
        logic write_line;
        logic set_dirty;
        logic clr_dirty;
    } ctrl_out_t;

    function automatic int beat_w(input int lw);
        return (lw > 1) ? $clog2(lw) : 1;
    endfunction

    // Moore strobes for a state; the REFILL data strobe is added outside
    // because it follows mem_ready within the cycle.
    function automatic ctrl_out_t decode_state(input state_e s,
                                               input logic   req_write,
                                               input logic   wb_mode);
        ctrl_out_t o;
        o = '0;
        case (s)
            IDLE, DONE: begin
                o.cpu_ready = 1'b1;
            end
            HIT: begin
                o.cpu_ready   = 1'b1;
                o.write_lru   = 1'b1;
                o.write_line  = 1'b1;
                o.write_cache = req_write;
                o.set_dirty   = req_write & wb_mode;
            end
            WT_WR, WB: begin
                o.mem_access = 1'b1;
                o.mem_write  = 1'b1;
            end
            REFILL: begin
                o.mem_access = 1'b1;
                o.mem_read   = 1'b1;
                o.fill_sel   = 1'b1;
            end
            FILL: begin
                o.cpu_ready   = 1'b1;
                o.write_tag   = 1'b1;
                o.write_lru   = 1'b1;
                o.write_line  = 1'b1;
                o.write_cache = req_write & wb_mode;
                o.set_dirty   = req_write & wb_mode;
                o.clr_dirty   = ~(req_write & wb_mode);
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_beat_counter.sv
// ============================================================================
// Module      : cache_beat_counter
// Description : Beat index counter for multi-beat line transfers, wrapping
//               to zero after the last beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_beat_counter
    import cache_ctrl_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    localparam int BEAT_W    = beat_w(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    output logic [BEAT_W-1:0] cnt_o,
    output logic              last_o
);

    localparam logic [BEAT_W-1:0] C_LAST = BEAT_W'(LINE_WORDS - 1);

    logic [BEAT_W-1:0] cnt_q;
    logic [BEAT_W-1:0] cnt_d;

    // With a single-word line C_LAST is 0, so the count never leaves 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/cache_ctrl_nway_wb.sv
// ============================================================================
// Module      : cache_ctrl_nway_wb
// Description : N-way set-associative cache controller FSM with multi-beat
//               refill/writeback and selectable write-back or write-through.
//               Define CACHE_CTRL_STATS_EN to add hit/miss/writeback counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_ctrl_nway_wb
    import cache_ctrl_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int WRITE_BACK = 1,
    localparam int BEAT_W    = beat_w(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_access,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              hit,
    input  logic              victim_dirty,
    input  logic              mem_ready,
    output logic              cpu_ready,
    output logic              mem_access,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              write_cache,
    output logic              fill_sel,
    output logic              write_tag,
    output logic              write_lru,
    output logic              write_line,
    output logic              set_dirty,
    output logic              clr_dirty
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wb_count
`endif
);

    localparam logic C_WB_MODE = (WRITE_BACK != 0);

    generate
        if (WAYS < 2 || LINE_WORDS < 1 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_param
            $error("cache_ctrl_nway_wb: WAYS must be >= 2 and LINE_WORDS a power of 2");
        end
    endgenerate

    state_e    state_q, state_d;
    logic      req_write_q, req_write_d;
    logic      req_hit_q, req_hit_d;
    ctrl_out_t out_q, out_d;

    logic      w_cnt_en;
    logic      w_cnt_clr;
    logic      w_cnt_last;
    logic      w_lookup_exit;

    cache_beat_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_beat_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_cnt_clr),
        .en_i   (w_cnt_en),
        .cnt_o  (beat_idx),
        .last_o (w_cnt_last)
    );

    // Idle clear keeps the count aligned even if a transfer is ever abandoned.
    assign w_cnt_clr     = (state_q == IDLE);
    assign w_lookup_exit = (state_q == LOOKUP) && (cpu_read || cpu_write);

    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_hit_d   = req_hit_q;
        w_cnt_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_access) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (w_lookup_exit) begin
                    req_write_d = cpu_write & ~cpu_read;
                    req_hit_d   = hit;
                    if (hit) begin
                        state_d = (cpu_read || C_WB_MODE) ? HIT : WT_WR;
                    end else if (!C_WB_MODE && !cpu_read) begin
                        state_d = WT_WR;
                    end else if (C_WB_MODE && victim_dirty) begin
                        state_d = WB;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            HIT, FILL, DONE: begin
                state_d = IDLE;
            end
            WT_WR: begin
                if (mem_ready) state_d = req_hit_q ? HIT : DONE;
            end
            WB: begin
                w_cnt_en = mem_ready;
                if (mem_ready && w_cnt_last) state_d = REFILL;
            end
            REFILL: begin
                w_cnt_en = mem_ready;
                if (mem_ready && w_cnt_last) state_d = FILL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_d = decode_state(state_d, req_write_d, C_WB_MODE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_write_q <= 1'b0;
            req_hit_q   <= 1'b0;
            out_q       <= decode_state(IDLE, 1'b0, C_WB_MODE);
        end else begin
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_hit_q   <= req_hit_d;
            out_q       <= out_d;
        end
    end

    assign cpu_ready   = out_q.cpu_ready;
    assign mem_access  = out_q.mem_access;
    assign mem_read    = out_q.mem_read;
    assign mem_write   = out_q.mem_write;
    assign write_cache = out_q.write_cache | ((state_q == REFILL) & mem_ready);
    assign fill_sel    = out_q.fill_sel;
    assign write_tag   = out_q.write_tag;
    assign write_lru   = out_q.write_lru;
    assign write_line  = out_q.write_line;
    assign set_dirty   = out_q.set_dirty;
    assign clr_dirty   = out_q.clr_dirty;

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_count_q, miss_count_q, wb_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            if (w_lookup_exit && hit)  hit_count_q  <= hit_count_q + 32'd1;
            if (w_lookup_exit && !hit) miss_count_q <= miss_count_q + 32'd1;
            if (w_lookup_exit && state_d == WB) wb_count_q <= wb_count_q + 32'd1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl_nway_wb.sv
// ============================================================================
// Module      : tb_cache_ctrl_nway_wb
// Description : Randomized self-checking bench for cache_ctrl_nway_wb over
//               three configurations against a transaction-plan model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_ctrl_nway_wb;

    localparam int K_IDLE = 0, K_LOOK = 1, K_HIT = 2, K_WT = 3,
                   K_WB = 4, K_RF = 5, K_FILL = 6, K_DONE = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cpu_access, cpu_read, cpu_write, hit, victim_dirty, mem_ready;
    int   sel;
    int   pct;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lw_of [3] = '{4, 2, 1};
    bit   wb_of [3] = '{1'b1, 1'b0, 1'b1};
    int   e_hit [3] = '{0, 0, 0};
    int   e_miss[3] = '{0, 0, 0};
    int   e_wb  [3] = '{0, 0, 0};

    wire [2:0]  acc = {cpu_access & (sel == 2), cpu_access & (sel == 1), cpu_access & (sel == 0)};
    wire [10:0] o_a, o_b, o_c;
    wire [1:0]  beat_a;
    wire [0:0]  beat_b, beat_c;
    wire [10:0] obs      = (sel == 0) ? o_a : (sel == 1) ? o_b : o_c;
    wire [7:0]  obs_beat = (sel == 0) ? {6'd0, beat_a} : (sel == 1) ? {7'd0, beat_b} : {7'd0, beat_c};

`ifdef CACHE_CTRL_STATS_EN
    wire [31:0] hc_a, mc_a, wc_a, hc_b, mc_b, wc_b, hc_c, mc_c, wc_c;
`endif

    cache_ctrl_nway_wb #(.WAYS(4), .LINE_WORDS(4), .WRITE_BACK(1)) u_dut_a (
        .clk(clk), .rst(rst), .cpu_access(acc[0]), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .hit(hit), .victim_dirty(victim_dirty), .mem_ready(mem_ready),
        .cpu_ready(o_a[10]), .mem_access(o_a[9]), .mem_read(o_a[8]), .mem_write(o_a[7]),
        .beat_idx(beat_a), .write_cache(o_a[6]), .fill_sel(o_a[5]), .write_tag(o_a[4]),
        .write_lru(o_a[3]), .write_line(o_a[2]), .set_dirty(o_a[1]), .clr_dirty(o_a[0])
`ifdef CACHE_CTRL_STATS_EN
        , .hit_count(hc_a), .miss_count(mc_a), .wb_count(wc_a)
`endif
    );

    cache_ctrl_nway_wb #(.WAYS(2), .LINE_WORDS(2), .WRITE_BACK(0)) u_dut_b (
        .clk(clk), .rst(rst), .cpu_access(acc[1]), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .hit(hit), .victim_dirty(victim_dirty), .mem_ready(mem_ready),
        .cpu_ready(o_b[10]), .mem_access(o_b[9]), .mem_read(o_b[8]), .mem_write(o_b[7]),
        .beat_idx(beat_b), .write_cache(o_b[6]), .fill_sel(o_b[5]), .write_tag(o_b[4]),
        .write_lru(o_b[3]), .write_line(o_b[2]), .set_dirty(o_b[1]), .clr_dirty(o_b[0])
`ifdef CACHE_CTRL_STATS_EN
        , .hit_count(hc_b), .miss_count(mc_b), .wb_count(wc_b)
`endif
    );

    cache_ctrl_nway_wb #(.WAYS(8), .LINE_WORDS(1), .WRITE_BACK(1)) u_dut_c (
        .clk(clk), .rst(rst), .cpu_access(acc[2]), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .hit(hit), .victim_dirty(victim_dirty), .mem_ready(mem_ready),
        .cpu_ready(o_c[10]), .mem_access(o_c[9]), .mem_read(o_c[8]), .mem_write(o_c[7]),
        .beat_idx(beat_c), .write_cache(o_c[6]), .fill_sel(o_c[5]), .write_tag(o_c[4]),
        .write_lru(o_c[3]), .write_line(o_c[2]), .set_dirty(o_c[1]), .clr_dirty(o_c[0])
`ifdef CACHE_CTRL_STATS_EN
        , .hit_count(hc_c), .miss_count(mc_c), .wb_count(wc_c)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (sel %0d, t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
        end
    endtask

    // Expected strobes, bit order {cpu_ready, mem_access, mem_read, mem_write,
    // write_cache, fill_sel, write_tag, write_lru, write_line, set_dirty, clr_dirty}.
    function automatic logic [10:0] exp_vec(input int k, input bit w, input bit wbm, input bit rdy);
        logic [10:0] v;
        v = '0;
        case (k)
            K_IDLE, K_DONE: v[10] = 1'b1;
            K_HIT:  begin v[10] = 1'b1; v[3] = 1'b1; v[2] = 1'b1; v[6] = w; v[1] = w & wbm; end
            K_WT, K_WB: begin v[9] = 1'b1; v[7] = 1'b1; end
            K_RF:   begin v[9] = 1'b1; v[8] = 1'b1; v[5] = 1'b1; v[6] = rdy; end
            K_FILL: begin
                v[10] = 1'b1; v[4] = 1'b1; v[3] = 1'b1; v[2] = 1'b1;
                v[6] = w & wbm; v[1] = w & wbm; v[0] = !(w & wbm);
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic noise();
        cpu_access   = 1'($urandom);
        cpu_read     = 1'($urandom);
        cpu_write    = 1'($urandom);
        hit          = 1'($urandom);
        victim_dirty = 1'($urandom);
        mem_ready    = ($urandom_range(0, 99) < pct);
    endtask

    task automatic step(input int k, input bit w, input int exp_beat, input string tag);
        @(negedge clk);
        noise();
        #1;
        chk(tag, 32'(obs), 32'(exp_vec(k, w, wb_of[sel], mem_ready)));
        chk({tag, "_beat"}, 32'(obs_beat), 32'(exp_beat));
    endtask

    task automatic run_txn(input int op, input bit h, input bit vd, input int abort_beat);
        bit rd, wr, w;
        int pk[$];
        int pn[$];
        int lw;
        bit wbm;
        rd  = (op != 1);
        wr  = (op != 0);
        w   = wr & ~rd;
        lw  = lw_of[sel];
        wbm = wb_of[sel];

        @(negedge clk);
        noise();
        cpu_access = 1'b1;
        #1;
        chk("idle", 32'(obs), 32'(exp_vec(K_IDLE, 1'b0, wbm, mem_ready)));
        chk("idle_beat", 32'(obs_beat), 32'd0);

        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            noise();
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
            #1;
            chk("lookup_wait", 32'(obs), 32'(exp_vec(K_LOOK, 1'b0, wbm, mem_ready)));
        end
        @(negedge clk);
        noise();
        cpu_read = rd; cpu_write = wr; hit = h; victim_dirty = vd;
        #1;
        chk("lookup", 32'(obs), 32'(exp_vec(K_LOOK, 1'b0, wbm, mem_ready)));

        if (h && (rd || wbm)) begin
            pk.push_back(K_HIT); pn.push_back(0);
        end else if (h) begin
            pk.push_back(K_WT); pn.push_back(1);
            pk.push_back(K_HIT); pn.push_back(0);
        end else if (!rd && !wbm) begin
            pk.push_back(K_WT); pn.push_back(1);
            pk.push_back(K_DONE); pn.push_back(0);
        end else begin
            if (wbm && vd) begin
                pk.push_back(K_WB); pn.push_back(lw);
                e_wb[sel]++;
            end
            pk.push_back(K_RF); pn.push_back(lw);
            pk.push_back(K_FILL); pn.push_back(0);
        end
        if (h) e_hit[sel]++; else e_miss[sel]++;

        foreach (pk[i]) begin
            if (pn[i] == 0) begin
                step(pk[i], w, 0, "single");
            end else begin
                int b = 0;
                int guard = 0;
                while (b < pn[i]) begin
                    if (pk[i] == K_RF && b == abort_beat) begin
                        @(negedge clk);
                        noise();
                        rst = 1'b1;
                        #1;
                        chk("abort_rf", 32'(obs), 32'(exp_vec(K_RF, w, wbm, mem_ready)));
                        @(negedge clk);
                        cpu_access = 1'b0;
                        #1;
                        chk("abort_idle", 32'(obs), 32'(exp_vec(K_IDLE, 1'b0, wbm, 1'b0)));
                        chk("abort_beat", 32'(obs_beat), 32'd0);
                        rst = 1'b0;
                        for (int j = 0; j < 3; j++) begin
                            e_hit[j] = 0; e_miss[j] = 0; e_wb[j] = 0;
                        end
                        return;
                    end
                    step(pk[i], w, (pk[i] == K_WT) ? 0 : b, (pk[i] == K_WT) ? "wt_wr" :
                         (pk[i] == K_WB) ? "writeback" : "refill");
                    if (mem_ready) b++;
                    guard++;
                    if (guard > 400) begin
                        chk("transfer_timeout", 32'(guard), 32'(pn[i]));
                        break;
                    end
                end
            end
        end
        @(negedge clk);
        cpu_access = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 0; pct = 100;
        cpu_access = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        hit = 1'b0; victim_dirty = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_a", 32'(o_a), 32'h400);
        chk("reset_b", 32'(o_b), 32'h400);
        chk("reset_c", 32'(o_c), 32'h400);
        chk("reset_beat_a", 32'(beat_a), 32'd0);
        rst = 1'b0;

        // Directed: read hit, dirty write miss at full speed, then random traffic.
        sel = 0; pct = 100;
        run_txn(0, 1'b1, 1'b0, -1);
        run_txn(1, 1'b0, 1'b1, -1);
        pct = 50;
        run_txn(0, 1'b0, 1'b0, -1);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int n = 0; n < 40; n++) begin
                case ($urandom_range(0, 2))
                    0: pct = 100;
                    1: pct = 50;
                    default: pct = 25;
                endcase
                run_txn(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), -1);
            end
`ifdef CACHE_CTRL_STATS_EN
            #1;
            chk("hit_count",  (s == 0) ? hc_a : (s == 1) ? hc_b : hc_c, 32'(e_hit[s]));
            chk("miss_count", (s == 0) ? mc_a : (s == 1) ? mc_b : mc_c, 32'(e_miss[s]));
            chk("wb_count",   (s == 0) ? wc_a : (s == 1) ? wc_b : wc_c, 32'(e_wb[s]));
`endif
        end

        // Reset in the middle of a refill, then a normal read.
        sel = 0; pct = 100;
        run_txn(0, 1'b0, 1'b0, 2);
        run_txn(0, 1'b0, 1'b1, -1);
        run_txn(0, 1'b1, 1'b0, -1);
`ifdef CACHE_CTRL_STATS_EN
        #1;
        chk("hit_count_after_rst",  hc_a, 32'(e_hit[0]));
        chk("miss_count_after_rst", mc_a, 32'(e_miss[0]));
        chk("wb_count_after_rst",   wc_a, 32'(e_wb[0]));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
